div_result_bcd: RTL and testbench

- Sequential binary-to-BCD converter directly downstream of divider_8bit.
- Captures the divider's quotient, remainder and not_valid flag, then converts quotient and remainder to packed BCD using shift-add-3 (double dabble).
- Converts one bit per clock and feeds the display/readout logic.
- Start/idle handshake matches the divider's, so the divider's idle rising edge can drive strt directly.

---
 rtl/div_result_bcd_if.sv | 26 ++
 rtl/div_result_bcd.sv | 155 +++++++++++++++
 tb/tb_div_result_bcd.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/div_result_bcd_if.sv
// Handshake and result bundle between divider_8bit and the BCD converter.
// The master side feeds results in; the slave side returns packed BCD.
interface div_result_bcd_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  strt;
  logic [WIDTH-1:0]      quotient;
  logic [WIDTH-1:0]      remainder;
  logic                  not_valid;
  logic [4*DIGITS-1:0]   q_bcd;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  err;
  logic                  done;
  logic                  idle;

  modport master (
    output strt, quotient, remainder, not_valid,
    input  q_bcd, r_bcd, err, done, idle
  );

  modport slave (
    input  strt, quotient, remainder, not_valid,
    output q_bcd, r_bcd, err, done, idle
  );
endinterface

// File: rtl/div_result_bcd.sv
// Sequential double-dabble converter for divider quotient and remainder.
// One bit per clock: quotient first, then remainder, then a DONE pulse.
module div_result_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  div_result_bcd_if.slave  bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV_Q,
    S_CONV_R,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [BW-1:0]   work_q, work_d;
  logic [BW-1:0]   qhold_q, qhold_d;
  logic [BW-1:0]   q_bcd_q, q_bcd_d;
  logic [BW-1:0]   r_bcd_q, r_bcd_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            idle_q, idle_d;

  logic [BW-1:0]   adj;
  logic [BW-1:0]   work_step;
  logic [WIDTH-1:0] sh_step;
  logic            last;

  // Per-nibble +3 with no carry across digit boundaries.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  always_comb begin
    adj       = add3(work_q);
    work_step = {adj[BW-2:0], sh_q[WIDTH-1]};
    sh_step   = {sh_q[WIDTH-2:0], 1'b0};
    last      = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    rem_d   = rem_q;
    work_d  = work_q;
    qhold_d = qhold_q;
    q_bcd_d = q_bcd_q;
    r_bcd_d = r_bcd_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.strt) begin
          sh_d   = bus.quotient;
          rem_d  = bus.remainder;
          cnt_d  = '0;
          work_d = '0;
          if (bus.not_valid) begin
            q_bcd_d = '1;
            r_bcd_d = '1;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_CONV_Q;
          end
        end
      end
      S_CONV_Q: begin
        work_d = work_step;
        sh_d   = sh_step;
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          qhold_d = work_step;
          work_d  = '0;
          sh_d    = rem_q;
          cnt_d   = '0;
          state_d = S_CONV_R;
        end
      end
      S_CONV_R: begin
        work_d = work_step;
        sh_d   = sh_step;
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          q_bcd_d = qhold_q;
          r_bcd_d = work_step;
          err_d   = 1'b0;
          work_d  = '0;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    done_d = (state_d == S_DONE);
    idle_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      rem_q   <= '0;
      work_q  <= '0;
      qhold_q <= '0;
      q_bcd_q <= '0;
      r_bcd_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      rem_q   <= rem_d;
      work_q  <= work_d;
      qhold_q <= qhold_d;
      q_bcd_q <= q_bcd_d;
      r_bcd_q <= r_bcd_d;
      err_q   <= err_d;
      done_q  <= done_d;
      idle_q  <= idle_d;
    end
  end

  assign bus.q_bcd = q_bcd_q;
  assign bus.r_bcd = r_bcd_q;
  assign bus.err   = err_q;
  assign bus.done  = done_q;
  assign bus.idle  = idle_q;

endmodule

// File: tb/tb_div_result_bcd.sv
// Scoreboard bench: driver queues decimal-model results, monitor checks
// each done pulse for value, error flag, latency and idle return.
module tb_div_result_bcd;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_fail;
  bit   idle_due;
  bit   stim_done;

  typedef struct {
    logic [11:0] q;
    logic [11:0] r;
    logic        e;
    int          at;
  } exp_t;

  exp_t sb[$];

  div_result_bcd_if #(.WIDTH(8), .DIGITS(3)) bif ();

  div_result_bcd #(.WIDTH(8), .DIGITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_run(input int q, input int r, input bit nv,
                            input int e0);
    exp_t x;
    x.q  = nv ? 12'hFFF : to_bcd(q);
    x.r  = nv ? 12'hFFF : to_bcd(r);
    x.e  = nv;
    x.at = nv ? e0 : e0 + 16;
    sb.push_back(x);
  endtask

  // Drive strt for hold edges starting at the next posedge (E0).
  task automatic start(input int q, input int r, input bit nv,
                       input int hold, output int e0);
    @(negedge clk);
    bif.quotient  = 8'(q);
    bif.remainder = 8'(r);
    bif.not_valid = nv;
    bif.strt      = 1'b1;
    e0 = cyc + 1;
    expect_run(q, r, nv, e0);
    repeat (hold) @(negedge clk);
    bif.strt = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bif.idle && sb.size() == 0 && !idle_due) && n < 200);
    if (n >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout waiting for idle, queue=%0d", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input int q, input int r, input bit nv);
    int e0;
    start(q, r, nv, 1, e0);
    wait_idle();
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    exp_t x;
    idle_due = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && idle_due) begin
        chk("idle_after_done", 32'(bif.idle), 32'd1);
        idle_due = 1'b0;
      end
      if (rst && bif.done) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          x = sb.pop_front();
          chk("q_bcd", 32'(bif.q_bcd), 32'(x.q));
          chk("r_bcd", 32'(bif.r_bcd), 32'(x.r));
          chk("err", 32'(bif.err), 32'(x.e));
          chk("latency", 32'(cyc), 32'(x.at));
          chk("idle_low_in_done", 32'(bif.idle), 32'd0);
          idle_due = 1'b1;
        end
      end
    end
  end

  initial begin
    int e0;
    int q;
    int r;
    bit nv;
    n_chk     = 0;
    n_fail    = 0;
    stim_done = 1'b0;
    rst           = 1'b0;
    bif.strt      = 1'b0;
    bif.quotient  = '0;
    bif.remainder = '0;
    bif.not_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_idle", 32'(bif.idle), 32'd1);
    chk("rst_done", 32'(bif.done), 32'd0);
    chk("rst_q", 32'(bif.q_bcd), 32'd0);
    chk("rst_r", 32'(bif.r_bcd), 32'd0);
    chk("rst_err", 32'(bif.err), 32'd0);
    rst = 1'b1;

    run(5, 0, 1'b0);
    run(2, 18, 1'b0);
    run(255, 254, 1'b0);
    run(0, 96, 1'b1);
    chk("err_persists", 32'(bif.err), 32'd1);
    run(7, 3, 1'b0);
    chk("result_persists", 32'(bif.q_bcd), 32'h007);

    // Held start: 10 edges gives one run, 20 edges gives two.
    start(42, 17, 1'b0, 10, e0);
    wait_idle();
    start(99, 9, 1'b0, 20, e0);
    expect_run(99, 9, 1'b0, e0 + 18);
    wait_idle();

    // Inputs changed after capture must be ignored.
    start(10, 0, 1'b0, 1, e0);
    repeat (2) @(negedge clk);
    bif.quotient  = 8'd99;
    bif.remainder = 8'd55;
    bif.not_valid = 1'b1;
    wait_idle();
    bif.not_valid = 1'b0;

    // Reset during the quotient pass discards the conversion.
    run(123, 45, 1'b0);
    start(200, 100, 1'b0, 1, e0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    void'(sb.pop_back());
    chk("mid_rst_idle", 32'(bif.idle), 32'd1);
    chk("mid_rst_done", 32'(bif.done), 32'd0);
    chk("mid_rst_q", 32'(bif.q_bcd), 32'd0);
    chk("mid_rst_r", 32'(bif.r_bcd), 32'd0);
    chk("mid_rst_err", 32'(bif.err), 32'd0);
    rst = 1'b1;
    run(64, 8, 1'b0);

    for (int i = 0; i < 40; i++) begin
      q  = int'($urandom_range(0, 255));
      r  = int'($urandom_range(0, 255));
      nv = ($urandom_range(0, 7) == 0);
      run(q, r, nv);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    stim_done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    if (!stim_done) begin
      $display("FAIL global_timeout at cycle %0d", cyc);
      $fatal(1, "bench timed out");
    end
  end

endmodule
